mgmt_sram_arbiter: RTL and testbench

Banked SRAM arbiter that sits between the management core's memory port, the housekeeping read-only port and BANKS single-port DFFRAM macros inside the management core wrapper. It generalises the fixed one-CPU/one-RAM hookup to a parametrised number of banks, data width and depth. It adds grant handshakes, per-bank arbitration with concurrent access to distinct banks, and a starvation guard for the read-only port.

---
 rtl/mgmt_sram_arbiter.sv | 151 +++++++++++++++
 tb/tb_mgmt_sram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mgmt_sram_arbiter.sv
// Banked SRAM arbiter: CPU read/write port and housekeeping read-only port onto BANKS DFFRAM macros.
// Define MGMT_SRAM_STARVE_GUARD_EN to let a starved RO port win a same-bank conflict.
module mgmt_sram_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned BANKS      = 2,
  parameter int unsigned STARVE_MAX = 4,
  localparam int unsigned BANK_W    = $clog2(BANKS),
  localparam int unsigned BYTES     = DATA_W / 8,
  localparam int unsigned AW        = ADDR_W + BANK_W
) (
  input  logic                      core_clk,
  input  logic                      core_rstn,
  input  logic                      cpu_en,
  input  logic [BYTES-1:0]          cpu_we,
  input  logic [AW-1:0]             cpu_a,
  input  logic [DATA_W-1:0]         cpu_di,
  output logic                      cpu_gnt,
  output logic                      cpu_rvalid,
  output logic [DATA_W-1:0]         cpu_do,
  input  logic                      ro_req,
  input  logic [AW-1:0]             ro_addr,
  output logic                      ro_gnt,
  output logic                      ro_rvalid,
  output logic [DATA_W-1:0]         ro_data,
  output logic [BANKS-1:0]          ram_en,
  output logic [BANKS*BYTES-1:0]    ram_we,
  output logic [BANKS*ADDR_W-1:0]   ram_a,
  output logic [DATA_W-1:0]         ram_di,
  input  logic [BANKS*DATA_W-1:0]   ram_do
);

  // Low-order interleave: bank in the LSBs, row above
  logic [BANK_W-1:0] cpu_bank;
  logic [BANK_W-1:0] ro_bank;
  logic [ADDR_W-1:0] cpu_row;
  logic [ADDR_W-1:0] ro_row;

  assign cpu_bank = cpu_a[BANK_W-1:0];
  assign ro_bank  = ro_addr[BANK_W-1:0];
  assign cpu_row  = cpu_a[AW-1:BANK_W];
  assign ro_row   = ro_addr[AW-1:BANK_W];

  logic conflict;
  logic ro_force;

  assign conflict = cpu_en & ro_req & (cpu_bank == ro_bank);

`ifdef MGMT_SRAM_STARVE_GUARD_EN
  logic [3:0] starve_q;
  logic [3:0] starve_d;

  assign ro_force = conflict & (starve_q == 4'(STARVE_MAX));

  // Counts consecutive RO losses; any grant or dropped request restarts it
  always_comb begin
    starve_d = starve_q;
    if (!ro_req || ro_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q < 4'(STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign ro_force = 1'b0;
`endif

  // Grants are combinational but forced low while reset is held
  assign cpu_gnt = core_rstn & cpu_en & ~ro_force;
  assign ro_gnt  = core_rstn & ro_req & (~conflict | ro_force);

  // Per-bank steering; the two grants never target the same bank
  always_comb begin
    ram_en = '0;
    ram_we = '0;
    ram_a  = '0;
    for (int unsigned b = 0; b < BANKS; b++) begin
      if (cpu_gnt && (cpu_bank == BANK_W'(b))) begin
        ram_en[b]                    = 1'b1;
        ram_we[b*BYTES +: BYTES]     = cpu_we;
        ram_a[b*ADDR_W +: ADDR_W]    = cpu_row;
      end else if (ro_gnt && (ro_bank == BANK_W'(b))) begin
        ram_en[b]                    = 1'b1;
        ram_a[b*ADDR_W +: ADDR_W]    = ro_row;
      end
    end
  end

  assign ram_di = cpu_di;

  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              ro_rvalid_q,  ro_rvalid_d;
  logic [BANK_W-1:0] cpu_bank_q,   cpu_bank_d;
  logic [BANK_W-1:0] ro_bank_q,    ro_bank_d;
  logic [DATA_W-1:0] cpu_hold_q,   cpu_hold_d;
  logic [DATA_W-1:0] ro_hold_q,    ro_hold_d;
  logic [DATA_W-1:0] cpu_rdata;
  logic [DATA_W-1:0] ro_rdata;

  // Return-data select by the bank captured at grant time
  always_comb begin
    cpu_rdata = '0;
    ro_rdata  = '0;
    for (int unsigned b = 0; b < BANKS; b++) begin
      if (cpu_bank_q == BANK_W'(b)) cpu_rdata = ram_do[b*DATA_W +: DATA_W];
      if (ro_bank_q == BANK_W'(b))  ro_rdata  = ram_do[b*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    cpu_rvalid_d = cpu_gnt && (cpu_we == '0);
    ro_rvalid_d  = ro_gnt;
    cpu_bank_d   = cpu_rvalid_d ? cpu_bank : cpu_bank_q;
    ro_bank_d    = ro_rvalid_d ? ro_bank : ro_bank_q;
    cpu_hold_d   = cpu_rvalid_q ? cpu_rdata : cpu_hold_q;
    ro_hold_d    = ro_rvalid_q ? ro_rdata : ro_hold_q;
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      cpu_rvalid_q <= 1'b0;
      ro_rvalid_q  <= 1'b0;
      cpu_bank_q   <= '0;
      ro_bank_q    <= '0;
      cpu_hold_q   <= '0;
      ro_hold_q    <= '0;
    end else begin
      cpu_rvalid_q <= cpu_rvalid_d;
      ro_rvalid_q  <= ro_rvalid_d;
      cpu_bank_q   <= cpu_bank_d;
      ro_bank_q    <= ro_bank_d;
      cpu_hold_q   <= cpu_hold_d;
      ro_hold_q    <= ro_hold_d;
    end
  end

  // Live RAM data during rvalid, held copy otherwise
  assign cpu_rvalid = cpu_rvalid_q;
  assign ro_rvalid  = ro_rvalid_q;
  assign cpu_do     = cpu_hold_d;
  assign ro_data    = ro_hold_d;

endmodule

// File: tb/tb_mgmt_sram_arbiter.sv
// Bench for mgmt_sram_arbiter with a behavioural write-then-read RAM and read-data scoreboard.
`timescale 1ns/1ps
module tb_mgmt_sram_arbiter;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned BANKS      = 2;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned BYTES      = 4;
  localparam int unsigned AW         = 9;

  logic                     core_clk = 1'b0;
  logic                     core_rstn = 1'b0;
  logic                     cpu_en = 1'b0;
  logic [BYTES-1:0]         cpu_we = '0;
  logic [AW-1:0]            cpu_a = '0;
  logic [DATA_W-1:0]        cpu_di = '0;
  logic                     cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0]        cpu_do;
  logic                     ro_req = 1'b0;
  logic [AW-1:0]            ro_addr = '0;
  logic                     ro_gnt, ro_rvalid;
  logic [DATA_W-1:0]        ro_data;
  logic [BANKS-1:0]         ram_en;
  logic [BANKS*BYTES-1:0]   ram_we;
  logic [BANKS*ADDR_W-1:0]  ram_a;
  logic [DATA_W-1:0]        ram_di;
  logic [BANKS*DATA_W-1:0]  ram_do;

  mgmt_sram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANKS(BANKS), .STARVE_MAX(STARVE_MAX)) dut (
    .core_clk(core_clk), .core_rstn(core_rstn),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_di(cpu_di),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_do(cpu_do),
    .ro_req(ro_req), .ro_addr(ro_addr), .ro_gnt(ro_gnt), .ro_rvalid(ro_rvalid), .ro_data(ro_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do)
  );

  always #5 core_clk = ~core_clk;

  // Behavioural single-port RAM per bank, write-then-read, data the cycle after enable
  logic [DATA_W-1:0] mem [0:BANKS-1][0:255];
  logic [DATA_W-1:0] ram_w;
  always @(posedge core_clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (ram_en[b]) begin
        ram_w = mem[b][ram_a[b*ADDR_W +: ADDR_W]];
        for (int k = 0; k < BYTES; k++)
          if (ram_we[b*BYTES+k]) ram_w[k*8 +: 8] = ram_di[k*8 +: 8];
        mem[b][ram_a[b*ADDR_W +: ADDR_W]] <= ram_w;
        ram_do[b*DATA_W +: DATA_W] <= ram_w;
      end
    end
  end

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [DATA_W-1:0] cpu_exp_q[$];
  logic [DATA_W-1:0] ro_exp_q[$];
  logic [DATA_W-1:0] shadow [0:511];
  logic [DATA_W-1:0] sb_exp;

  // Scoreboard: pop expected read data whenever an rvalid appears
  always begin
    @(posedge core_clk); #2;
    if (core_rstn) begin
      if (cpu_rvalid) begin
        vec_cnt++;
        if (cpu_exp_q.size() == 0) begin
          err_cnt++; $display("FAIL cpu_rvalid_extra: do=%h with no read outstanding", cpu_do);
        end else begin
          sb_exp = cpu_exp_q.pop_front();
          if (cpu_do !== sb_exp) begin
            err_cnt++; $display("FAIL cpu_rdata: got %h expected %h", cpu_do, sb_exp);
          end
        end
      end
      if (ro_rvalid) begin
        vec_cnt++;
        if (ro_exp_q.size() == 0) begin
          err_cnt++; $display("FAIL ro_rvalid_extra: data=%h with no read outstanding", ro_data);
        end else begin
          sb_exp = ro_exp_q.pop_front();
          if (ro_data !== sb_exp) begin
            err_cnt++; $display("FAIL ro_rdata: got %h expected %h", ro_data, sb_exp);
          end
        end
      end
    end
  end

  task automatic cyc_begin();
    @(posedge core_clk); #1;
  endtask

  task automatic go_idle();
    cyc_begin();
    cpu_en = 1'b0; cpu_we = '0; ro_req = 1'b0;
    @(negedge core_clk);
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DATA_W-1:0] d, input logic [BYTES-1:0] we);
    cyc_begin();
    cpu_en = 1'b1; cpu_we = we; cpu_a = a; cpu_di = d; ro_req = 1'b0;
    @(negedge core_clk);
    if (cpu_gnt)
      for (int k = 0; k < BYTES; k++) if (we[k]) shadow[a][k*8 +: 8] = d[k*8 +: 8];
  endtask

  task automatic test_reset();
    core_rstn = 1'b0; cpu_en = 1'b1; cpu_we = '0; cpu_a = 9'h001; ro_req = 1'b1; ro_addr = 9'h002;
    repeat (3) @(posedge core_clk);
    @(negedge core_clk);
    vec_cnt++; if (cpu_gnt !== 1'b0 || ro_gnt !== 1'b0) begin
      err_cnt++; $display("FAIL rst_gnt: cpu_gnt=%b ro_gnt=%b expected 0 0", cpu_gnt, ro_gnt); end
    vec_cnt++; if (ram_en !== 2'b00 || ram_we !== 8'h00) begin
      err_cnt++; $display("FAIL rst_ram: ram_en=%b ram_we=%h expected 0 0", ram_en, ram_we); end
    vec_cnt++; if (cpu_rvalid !== 1'b0 || ro_rvalid !== 1'b0) begin
      err_cnt++; $display("FAIL rst_rvalid: cpu=%b ro=%b expected 0 0", cpu_rvalid, ro_rvalid); end
    vec_cnt++; if (cpu_do !== 32'h0 || ro_data !== 32'h0) begin
      err_cnt++; $display("FAIL rst_data: cpu_do=%h ro_data=%h expected 0 0", cpu_do, ro_data); end
  endtask

  task automatic test_write_read();
    // Release reset with a write already pending: grant in the first cycle
    cyc_begin();
    core_rstn = 1'b1; ro_req = 1'b0;
    cpu_en = 1'b1; cpu_we = 4'hF; cpu_a = 9'h003; cpu_di = 32'hDEADBEEF;
    @(negedge core_clk);
    vec_cnt++; if (cpu_gnt !== 1'b1 || ram_en !== 2'b10 || ram_we !== 8'hF0 || ram_a[15:8] !== 8'h01) begin
      err_cnt++; $display("FAIL wr_issue: gnt=%b en=%b we=%h a=%h expected 1 10 f0 01xx", cpu_gnt, ram_en, ram_we, ram_a); end
    shadow[3] = 32'hDEADBEEF;
    cyc_begin();
    cpu_we = 4'h0; cpu_di = 32'h0;
    @(negedge core_clk);
    vec_cnt++; if (cpu_rvalid !== 1'b0) begin
      err_cnt++; $display("FAIL wr_no_rvalid: cpu_rvalid=%b expected 0", cpu_rvalid); end
    vec_cnt++; if (cpu_gnt !== 1'b1 || ram_en !== 2'b10 || ram_we !== 8'h00) begin
      err_cnt++; $display("FAIL rd_issue: gnt=%b en=%b we=%h expected 1 10 00", cpu_gnt, ram_en, ram_we); end
    if (cpu_gnt) cpu_exp_q.push_back(32'hDEADBEEF);
    go_idle();
    vec_cnt++; if (cpu_rvalid !== 1'b1 || ram_en !== 2'b00) begin
      err_cnt++; $display("FAIL rd_latency: rvalid=%b en=%b expected 1 00", cpu_rvalid, ram_en); end
  endtask

  task automatic test_concurrent();
    cpu_write(9'h002, 32'hA5A50002, 4'hF);
    cpu_write(9'h005, 32'h5A5A0005, 4'hF);
    cyc_begin();
    cpu_en = 1'b1; cpu_we = '0; cpu_a = 9'h002; ro_req = 1'b1; ro_addr = 9'h005;
    @(negedge core_clk);
    vec_cnt++; if (cpu_gnt !== 1'b1 || ro_gnt !== 1'b1 || ram_en !== 2'b11 || ram_a !== 16'h0201) begin
      err_cnt++; $display("FAIL dual_issue: cg=%b rg=%b en=%b a=%h expected 1 1 11 0201", cpu_gnt, ro_gnt, ram_en, ram_a); end
    if (cpu_gnt) cpu_exp_q.push_back(shadow[2]);
    if (ro_gnt) ro_exp_q.push_back(shadow[5]);
    go_idle();
    vec_cnt++; if (cpu_rvalid !== 1'b1 || ro_rvalid !== 1'b1) begin
      err_cnt++; $display("FAIL dual_rvalid: cpu=%b ro=%b expected 1 1", cpu_rvalid, ro_rvalid); end
  endtask

  task automatic test_byte_write();
    cpu_write(9'h004, 32'h11223344, 4'hF);
    cpu_write(9'h004, 32'h0000AA00, 4'b0010);
    vec_cnt++; if (ram_we !== 8'h02 || ram_en !== 2'b01) begin
      err_cnt++; $display("FAIL byte_we: ram_we=%h ram_en=%b expected 02 01", ram_we, ram_en); end
    cyc_begin();
    cpu_we = '0;
    @(negedge core_clk);
    if (cpu_gnt) cpu_exp_q.push_back(32'h1122AA44);
    go_idle();
    vec_cnt++; if (cpu_rvalid !== 1'b1) begin
      err_cnt++; $display("FAIL byte_rvalid: cpu_rvalid=%b expected 1", cpu_rvalid); end
  endtask

  task automatic test_adjacent();
    // CPU write beats RO on the shared bank; RO read next cycle sees the new word
    cyc_begin();
    cpu_en = 1'b1; cpu_we = 4'hF; cpu_a = 9'h007; cpu_di = 32'hC0FFEE07;
    ro_req = 1'b1; ro_addr = 9'h007;
    @(negedge core_clk);
    vec_cnt++; if (cpu_gnt !== 1'b1 || ro_gnt !== 1'b0) begin
      err_cnt++; $display("FAIL adj_conflict: cg=%b rg=%b expected 1 0", cpu_gnt, ro_gnt); end
    cyc_begin();
    cpu_en = 1'b0; cpu_we = '0;
    @(negedge core_clk);
    vec_cnt++; if (ro_gnt !== 1'b1 || ram_en !== 2'b10 || ram_we !== 8'h00) begin
      err_cnt++; $display("FAIL adj_ro_issue: rg=%b en=%b we=%h expected 1 10 00", ro_gnt, ram_en, ram_we); end
    if (ro_gnt) ro_exp_q.push_back(32'hC0FFEE07);
    go_idle();
    vec_cnt++; if (ro_rvalid !== 1'b1) begin
      err_cnt++; $display("FAIL adj_rvalid: ro_rvalid=%b expected 1", ro_rvalid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) cpu_write(AW'(9'h010 + i), 32'hB0B00000 | i, 4'hF);
    for (int i = 0; i < 8; i++) begin
      cyc_begin();
      cpu_en = 1'b1; cpu_we = '0; cpu_a = AW'(9'h010 + i); ro_req = 1'b0;
      @(negedge core_clk);
      vec_cnt++; if (cpu_gnt !== 1'b1 || cpu_rvalid !== (i > 0)) begin
        err_cnt++; $display("FAIL b2b_%0d: gnt=%b rvalid=%b expected 1 %b", i, cpu_gnt, cpu_rvalid, i > 0); end
      if (cpu_gnt) cpu_exp_q.push_back(shadow[9'h010 + i]);
    end
    go_idle();
  endtask

  task automatic test_starve();
    int i_win;
    cpu_write(9'h000, 32'h00C0FFEE, 4'hF);
    cpu_write(9'h006, 32'h60060006, 4'hF);
    i_win = 0;
    for (int i = 1; i <= 12; i++) begin
      logic exp_ro;
`ifdef MGMT_SRAM_STARVE_GUARD_EN
      exp_ro = (i == STARVE_MAX + 1);
`else
      exp_ro = 1'b0;
`endif
      cyc_begin();
      cpu_en = 1'b1; cpu_we = '0; cpu_a = 9'h000;
      ro_req = (i_win == 0); ro_addr = 9'h006;
      @(negedge core_clk);
      vec_cnt++; if (ro_gnt !== exp_ro || cpu_gnt !== !exp_ro) begin
        err_cnt++; $display("FAIL starve_c%0d: rg=%b cg=%b expected %b %b", i, ro_gnt, cpu_gnt, exp_ro, !exp_ro); end
      if (cpu_gnt) cpu_exp_q.push_back(shadow[0]);
      if (ro_gnt) begin ro_exp_q.push_back(shadow[6]); i_win = i; end
    end
    go_idle();
  endtask

  task automatic test_starve_clear();
    // A dropped RO request restarts the loss count
    int won;
    won = 0;
    for (int i = 1; i <= 10; i++) begin
      logic exp_ro;
`ifdef MGMT_SRAM_STARVE_GUARD_EN
      exp_ro = (i == 9);
`else
      exp_ro = 1'b0;
`endif
      cyc_begin();
      cpu_en = 1'b1; cpu_we = '0; cpu_a = 9'h000;
      ro_req = (i != 4) && (won == 0); ro_addr = 9'h006;
      @(negedge core_clk);
      vec_cnt++; if (ro_gnt !== exp_ro) begin
        err_cnt++; $display("FAIL starve_clr_c%0d: rg=%b expected %b", i, ro_gnt, exp_ro); end
      if (cpu_gnt) cpu_exp_q.push_back(shadow[0]);
      if (ro_gnt) begin ro_exp_q.push_back(shadow[6]); won = 1; end
    end
    go_idle();
  endtask

  task automatic test_reset_mid_read();
    cyc_begin();
    cpu_en = 1'b1; cpu_we = '0; cpu_a = 9'h003; ro_req = 1'b0;
    @(negedge core_clk);
    vec_cnt++; if (cpu_gnt !== 1'b1) begin
      err_cnt++; $display("FAIL rmr_gnt: cpu_gnt=%b expected 1", cpu_gnt); end
    cyc_begin();
    core_rstn = 1'b0; cpu_en = 1'b0;
    @(negedge core_clk);
    vec_cnt++; if (cpu_rvalid !== 1'b0 || cpu_do !== 32'h0) begin
      err_cnt++; $display("FAIL rmr_in_rst: rvalid=%b do=%h expected 0 0", cpu_rvalid, cpu_do); end
    repeat (2) @(posedge core_clk);
    #1 core_rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge core_clk);
      vec_cnt++; if (cpu_rvalid !== 1'b0 || cpu_do !== 32'h0) begin
        err_cnt++; $display("FAIL rmr_after_%0d: rvalid=%b do=%h expected 0 0", i, cpu_rvalid, cpu_do); end
      @(posedge core_clk);
    end
  endtask

  task automatic test_hold();
    cpu_write(9'h00A, 32'h12345678, 4'hF);
    cyc_begin();
    cpu_we = '0;
    @(negedge core_clk);
    if (cpu_gnt) cpu_exp_q.push_back(32'h12345678);
    go_idle();
    vec_cnt++; if (cpu_rvalid !== 1'b1) begin
      err_cnt++; $display("FAIL hold_rvalid: cpu_rvalid=%b expected 1", cpu_rvalid); end
    for (int i = 0; i < 10; i++) begin
      go_idle();
      vec_cnt++; if (cpu_rvalid !== 1'b0 || cpu_do !== 32'h12345678) begin
        err_cnt++; $display("FAIL hold_c%0d: rvalid=%b do=%h expected 0 12345678", i, cpu_rvalid, cpu_do); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_concurrent();
    test_byte_write();
    test_adjacent();
    test_back_to_back();
    test_starve();
    test_starve_clear();
    test_reset_mid_read();
    test_hold();
    go_idle();
    go_idle();
    vec_cnt++; if (cpu_exp_q.size() != 0 || ro_exp_q.size() != 0) begin
      err_cnt++; $display("FAIL drain: cpu reads pending=%0d ro reads pending=%0d expected 0 0",
                          cpu_exp_q.size(), ro_exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
